// File: rtl/fast_pkt_pkg.sv
// Shared FAST packet definitions for the UM datapath.
// Word codes, header offsets and the delay-line word bundle.
package fast_pkt_pkg;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;

    localparam logic [2:0] W_HEAD = 3'd0;
    localparam logic [2:0] W_ETH  = 3'd2;
    localparam logic [2:0] W_IP   = 3'd3;
    localparam logic [2:0] W_ICMP = 3'd4;
    localparam logic [2:0] W_BODY = 3'd5;

    localparam logic [15:0] ETH_IPV4      = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
    localparam logic [7:0]  IP_PROTO_ICMP = 8'h01;
    localparam logic [7:0]  ICMP_ECHO_REQ = 8'h08;
    localparam logic [7:0]  ICMP_ECHO_REP = 8'h00;

    localparam int PST_HI = 79;
    localparam int PST_LO = 72;

    typedef struct packed {
        logic [133:0] data;
        logic         wr;
        logic         valid;
        logic         valid_wr;
        logic [2:0]   widx;
    } fast_word_t;

    function automatic logic [15:0] cksum_add(input logic [15:0] ck,
                                              input logic [15:0] inc);
        logic [16:0] s;
        s = {1'b0, ck} + {1'b0, inc};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/pkt_dly_line.sv
// Fixed-depth word delay line; also exposes the DIP low half
// of the word one stage behind the output for the IP swap.
module pkt_dly_line
    import fast_pkt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  fast_word_t d,
    output fast_word_t q,
    output logic [15:0] nxt_dip_lo
);

    fast_word_t pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q          = pipe[DEPTH-1];
    assign nxt_dip_lo = pipe[DEPTH-2].data[127:112];

endmodule

// File: rtl/ping_responder.sv
// ICMP echo responder: classifies on input, rewrites delayed
// copies of requests into replies, counts good replies.
module ping_responder
    import fast_pkt_pkg::*;
#(
    parameter logic [7:0] REPLY_PST = 8'hfe,
    parameter int         LAT       = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_resp_en,
    input  logic [31:0]  cfg_local_ip,
    input  logic [133:0] in_resp_data,
    input  logic         in_resp_data_wr,
    input  logic         in_resp_data_valid,
    input  logic         in_resp_data_valid_wr,
    output logic [133:0] out_resp_data,
    output logic         out_resp_data_wr,
    output logic         out_resp_data_valid,
    output logic         out_resp_data_valid_wr,
    output logic [15:0]  reply_cnt
);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t      state;
    logic [2:0]  widx_q;
    logic [31:0] ip_q;
    logic        en_q, m2_q, m3_q, req_q;

    logic        head, tail, acc, req_now, push, req_al;
    logic [2:0]  widx;
    fast_word_t  din, dq;
    logic [15:0] nxt_dip_lo;

    assign head = in_resp_data[133:132] == HEAD;
    assign tail = in_resp_data[133:132] == TAIL;
    assign acc  = in_resp_data_wr & (head | (state != IDLE));
    assign widx = head ? W_HEAD :
                  (widx_q < W_BODY ? widx_q + 3'd1 : W_BODY);

    assign req_now = acc & ~head & (state == HDR) & (widx == W_ICMP)
                   & en_q & m2_q & m3_q
                   & (in_resp_data[127:112] == ip_q[15:0])
                   & (in_resp_data[111:104] == ICMP_ECHO_REQ)
                   & (in_resp_data[103:96] == 8'h00);

    assign push = acc & tail & in_resp_data_valid_wr
                & (req_now | ((state == BODY) & req_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            widx_q <= '0;
            ip_q   <= '0;
            en_q   <= 1'b0;
            m2_q   <= 1'b0;
            m3_q   <= 1'b0;
            req_q  <= 1'b0;
        end else if (acc) begin
            widx_q <= widx;
            if (head) begin
                state <= HDR;
                en_q  <= cfg_resp_en;
                ip_q  <= cfg_local_ip;
                m2_q  <= 1'b0;
                m3_q  <= 1'b0;
                req_q <= 1'b0;
            end else begin
                unique case (state)
                    HDR: begin
                        if (widx == W_ETH)
                            m2_q <= (in_resp_data[31:16] == ETH_IPV4)
                                  & (in_resp_data[15:8] == IPV4_VER_IHL);
                        if (widx == W_IP)
                            m3_q <= (in_resp_data[71:64] == IP_PROTO_ICMP)
                                  & (in_resp_data[15:0] == ip_q[31:16]);
                        if (widx == W_ICMP) req_q <= req_now;
                        if (tail) state <= IDLE;
                        else if (widx == W_ICMP) state <= BODY;
                    end
                    BODY: if (tail) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        din          = '0;
        din.wr       = acc;
        din.valid_wr = acc & in_resp_data_valid_wr;
        din.valid    = din.valid_wr & in_resp_data_valid;
        din.widx     = widx;
        if (acc) din.data = in_resp_data;
    end

    pkt_dly_line #(.DEPTH(LAT - 1)) u_dly (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (din),
        .q          (dq),
        .nxt_dip_lo (nxt_dip_lo)
    );

    // The w4 decision lands exactly when the packet's w0 reaches the muxes.
    generate
        if (LAT == 5) begin : g_al0
            assign req_al = req_now;
        end else begin : g_al
            logic [LAT-6:0] sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else begin
                    sr[0] <= req_now;
                    for (int i = 1; i < LAT - 5; i++) sr[i] <= sr[i-1];
                end
            end
            assign req_al = sr[LAT-6];
        end
    endgenerate

    logic         cur_req, out_req_q, w4_fire;
    logic [15:0]  sip_lo_q;
    logic [133:0] od;

    assign cur_req = (dq.wr && dq.widx == W_HEAD) ? req_al : out_req_q;
    assign w4_fire = dq.wr & cur_req & (dq.widx == W_ICMP);

    always_comb begin
        od = dq.data;
        if (dq.wr && cur_req) begin
            unique case (dq.widx)
                W_HEAD: od[PST_HI:PST_LO] = REPLY_PST;
                W_ETH: begin
                    od[127:80] = dq.data[79:32];
                    od[79:32]  = dq.data[127:80];
                end
                W_IP: begin
                    od[47:16] = {dq.data[15:0], nxt_dip_lo};
                    od[15:0]  = dq.data[47:32];
                end
                W_ICMP: begin
                    od[127:112] = sip_lo_q;
                    od[111:104] = ICMP_ECHO_REP;
                    od[95:80]   = cksum_add(dq.data[95:80], 16'h0800);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_resp_data          <= '0;
            out_resp_data_wr       <= 1'b0;
            out_resp_data_valid    <= 1'b0;
            out_resp_data_valid_wr <= 1'b0;
            out_req_q              <= 1'b0;
            sip_lo_q               <= '0;
        end else begin
            out_resp_data          <= od;
            out_resp_data_wr       <= dq.wr;
            out_resp_data_valid    <= dq.valid;
            out_resp_data_valid_wr <= dq.valid_wr;
            out_req_q              <= cur_req;
            if (dq.wr && dq.widx == W_IP) sip_lo_q <= dq.data[31:16];
        end
    end

    // Good/bad flags of replies whose tail beat their w4 to the output.
    logic [3:0] cf_mem;
    logic [1:0] cf_rd, cf_wr;
    logic [2:0] cf_cnt;
    logic       pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reply_cnt <= '0;
            cf_mem    <= '0;
            cf_rd     <= '0;
            cf_wr     <= '0;
            cf_cnt    <= '0;
            pend_q    <= 1'b0;
        end else if (w4_fire && cf_cnt != 3'd0) begin
            reply_cnt <= reply_cnt + {15'd0, cf_mem[cf_rd]};
            cf_rd     <= cf_rd + 2'd1;
            if (push) begin
                cf_mem[cf_wr] <= in_resp_data_valid;
                cf_wr         <= cf_wr + 2'd1;
            end else begin
                cf_cnt <= cf_cnt - 3'd1;
            end
        end else if ((w4_fire || pend_q) && push) begin
            reply_cnt <= reply_cnt + {15'd0, in_resp_data_valid};
            pend_q    <= 1'b0;
        end else if (w4_fire) begin
            pend_q <= 1'b1;
        end else if (push) begin
            cf_mem[cf_wr] <= in_resp_data_valid;
            cf_wr         <= cf_wr + 2'd1;
            cf_cnt        <= cf_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_ping_responder.sv
// Randomized bench for ping_responder against a packet-level
// reference model of echo request classification and reply.
module tb_ping_responder;

    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_resp_en = 1'b0;
    logic [31:0]  cfg_local_ip = '0;
    logic [133:0] in_d = '0;
    logic         in_wr = 1'b0, in_v = 1'b0, in_vw = 1'b0;
    logic [133:0] out_d;
    logic         out_wr, out_v, out_vw;
    logic [15:0]  reply_cnt;

    ping_responder dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .cfg_resp_en            (cfg_resp_en),
        .cfg_local_ip           (cfg_local_ip),
        .in_resp_data           (in_d),
        .in_resp_data_wr        (in_wr),
        .in_resp_data_valid     (in_v),
        .in_resp_data_valid_wr  (in_vw),
        .out_resp_data          (out_d),
        .out_resp_data_wr       (out_wr),
        .out_resp_data_valid    (out_v),
        .out_resp_data_valid_wr (out_vw),
        .reply_cnt              (reply_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [133:0] d;
        int           t;
        logic         v;
        logic         vw;
    } exp_t;

    exp_t         exp_q[$];
    logic [133:0] obs_q[$];
    bit           mon_en = 1'b1;
    logic [15:0]  exp_cnt = '0;
    exp_t         e;

    task automatic chk(input string tag, input logic [133:0] got,
                       input logic [133:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && out_wr) begin
            obs_q.push_back(out_d);
            if (exp_q.size() == 0) begin
                chk("extra_word", out_wr, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("word", out_d, e.d);
                chk("latency", cyc, e.t);
                chk("valid_wr", out_vw, e.vw);
                if (e.vw) chk("valid", out_v, e.v);
            end
        end
    end

    function automatic void mk_pkt(input int len, input int kind,
                                   input logic [31:0] ip,
                                   output logic [133:0] w[$]);
        logic [133:0] t;
        w.delete();
        for (int i = 0; i < len; i++) begin
            t[127:0] = {$urandom, $urandom, $urandom, $urandom};
            t[131:128] = (i == len - 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            t[133:132] = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
            if (i == 2) begin
                t[31:16] = (kind == 7) ? 16'h0806 : 16'h0800;
                t[15:8]  = (kind == 9) ? 8'h46 : 8'h45;
            end
            if (i == 3) begin
                t[71:64] = (kind == 6) ? 8'h11 : 8'h01;
                t[15:0]  = ip[31:16];
            end
            if (i == 4) begin
                t[127:112] = (kind == 4) ? ~ip[15:0] : ip[15:0];
                t[111:104] = (kind == 5) ? 8'h00 : 8'h08;
                t[103:96]  = (kind == 8) ? 8'h03 : 8'h00;
            end
            w.push_back(t);
        end
    endfunction

    function automatic bit model(input logic [133:0] w[$], input logic en,
                                 input logic [31:0] ip,
                                 output logic [133:0] r[$]);
        logic [133:0] t0, t2, t3, t4;
        logic [47:0]  dmac, smac;
        logic [31:0]  sip, dip, s;
        bit           req;
        r = w;
        req = 1'b0;
        if (w.size() >= 5) begin
            t0 = w[0]; t2 = w[2]; t3 = w[3]; t4 = w[4];
            dmac = t2[127:80];
            smac = t2[79:32];
            sip  = t3[47:16];
            dip  = {t3[15:0], t4[127:112]};
            req = en && t2[31:16] == 16'h0800 && t2[15:8] == 8'h45
               && t3[71:64] == 8'h01 && dip == ip
               && t4[111:104] == 8'h08 && t4[103:96] == 8'h00;
            if (req) begin
                t0[79:72] = 8'hfe;
                t2[127:80] = smac;
                t2[79:32]  = dmac;
                t3[47:16]  = dip;
                t3[15:0]   = sip[31:16];
                t4[127:112] = sip[15:0];
                t4[111:104] = 8'h00;
                s = {16'd0, t4[95:80]} + 32'h0800;
                if (s > 32'hffff) s = s - 32'hffff;
                t4[95:80] = s[15:0];
                r[0] = t0; r[2] = t2; r[3] = t3; r[4] = t4;
            end
        end
        return req;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_wr = 1'b0; in_vw = 1'b0; in_v = 1'b0;
            in_d = {2'($urandom), 4'h0, $urandom, $urandom, $urandom, $urandom};
            cfg_resp_en = 1'($urandom);
            cfg_local_ip = $urandom;
        end
    endtask

    task automatic drive(input logic [133:0] d, input logic last, input logic vld);
        @(posedge clk); #1;
        in_d = d; in_wr = 1'b1; in_vw = last;
        in_v = last ? vld : 1'($urandom);
    endtask

    task automatic send(input logic [133:0] w[$], input logic vld,
                        input logic en, input logic [31:0] ip, input int gap);
        logic [133:0] r[$];
        exp_t x;
        bit req;
        req = model(w, en, ip, r);
        if (req && vld) exp_cnt++;
        foreach (w[i]) begin
            drive(w[i], i == w.size() - 1, vld);
            if (i == 0) begin
                cfg_resp_en = en; cfg_local_ip = ip;
            end else begin
                cfg_resp_en = 1'($urandom); cfg_local_ip = $urandom;
            end
            x.d = r[i]; x.t = cyc + LAT; x.v = vld; x.vw = in_vw;
            exp_q.push_back(x);
        end
        idle(gap);
    endtask

    task automatic drain;
        int n = 0;
        idle(1);
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk); n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        idle(2);
    endtask

    localparam logic [31:0] IP0 = 32'h0a000001;

    logic [133:0] w[$];
    logic [133:0] t;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", out_d, '0);
        chk("rst_wr", out_wr, 1'b0);
        chk("rst_valid", out_v, 1'b0);
        chk("rst_valid_wr", out_vw, 1'b0);
        chk("rst_cnt", reply_cnt, 16'h0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        mk_pkt(8, 0, IP0, w);
        t = w[4]; t[95:80] = 16'h4d5a; w[4] = t;
        obs_q.delete();
        send(w, 1'b1, 1'b1, IP0, 2);
        drain();
        t = obs_q.size() > 0 ? obs_q[0] : '0;
        chk("t1_pst", t[79:72], 8'hfe);
        t = obs_q.size() > 4 ? obs_q[4] : '0;
        chk("t1_cksum", t[95:80], 16'h555a);
        chk("t1_type", t[111:104], 8'h00);
        chk("t1_cnt", reply_cnt, exp_cnt);

        mk_pkt(8, 0, IP0, w);
        t = w[4]; t[95:80] = 16'hf9ab; w[4] = t;
        obs_q.delete();
        send(w, 1'b1, 1'b1, IP0, 1);
        drain();
        t = obs_q.size() > 4 ? obs_q[4] : '0;
        chk("t2_cksum", t[95:80], 16'h01ac);
        chk("t2_cnt", reply_cnt, exp_cnt);

        for (int k = 4; k <= 9; k++) begin
            mk_pkt(8, k, IP0, w);
            send(w, 1'b1, 1'b1, IP0, $urandom_range(0, 2));
        end
        mk_pkt(8, 0, IP0, w);
        send(w, 1'b1, 1'b0, IP0, 1);
        mk_pkt(4, 0, IP0, w);
        send(w, 1'b1, 1'b1, IP0, 1);
        drain();
        chk("t3_cnt", reply_cnt, exp_cnt);

        mk_pkt(4, 0, IP0, w);
        send(w, 1'b1, 1'b1, IP0, 0);
        mk_pkt(8, 0, IP0, w);
        send(w, 1'b1, 1'b1, IP0, 0);
        drain();
        chk("t4_cnt", reply_cnt, exp_cnt);

        mk_pkt(8, 0, IP0, w);
        mon_en = 1'b0;
        cfg_resp_en = 1'b1; cfg_local_ip = IP0;
        for (int i = 0; i < 7; i++) drive(w[i], 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_data", out_d, '0);
        chk("t5_async_wr", out_wr, 1'b0);
        chk("t5_async_vwr", out_vw, 1'b0);
        chk("t5_async_cnt", reply_cnt, 16'h0);
        exp_q.delete();
        exp_cnt = '0;
        drive(w[7], 1'b1, 1'b1);
        idle(1);
        @(negedge clk) rst_n = 1'b1;
        mon_en = 1'b1;
        t = w[5]; drive(t, 1'b0, 1'b1);
        t = w[6]; drive(t, 1'b0, 1'b1);
        t = w[7]; drive(t, 1'b1, 1'b1);
        idle(1);
        mk_pkt(8, 0, IP0, w);
        send(w, 1'b1, 1'b1, IP0, 1);
        drain();
        chk("t5_cnt", reply_cnt, exp_cnt);

        mk_pkt(7, 0, IP0, w);
        send(w, 1'b0, 1'b1, IP0, 1);
        mk_pkt(6, 0, IP0, w);
        send(w, 1'b1, 1'b1, IP0, 1);
        drain();
        chk("t6_cnt", reply_cnt, exp_cnt);

        @(negedge clk);
        force dut.reply_cnt = 16'hfffe;
        @(posedge clk);
        @(negedge clk);
        release dut.reply_cnt;
        exp_cnt = 16'hfffe;
        for (int i = 0; i < 3; i++) begin
            mk_pkt(5 + i, 0, IP0, w);
            send(w, 1'b1, 1'b1, IP0, i);
        end
        drain();
        chk("wrap_cnt", reply_cnt, 16'h0001);

        for (int p = 0; p < 240; p++) begin
            logic [31:0] ip;
            ip = $urandom;
            mk_pkt($urandom_range(2, 12), $urandom_range(0, 9), ip, w);
            send(w, $urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0,
                 ip, $urandom_range(0, 3));
            if (p % 60 == 59) begin
                drain();
                chk("rand_cnt", reply_cnt, exp_cnt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
